// File: rtl/motion_ramp.sv
// Motion command sequencer: soft-start to a clamped duty, hold for N ms, soft-stop, pulse done.
// Drives timeon/enable of one pwm instance plus the motor direction line.
module motion_ramp #(
  parameter int CLK_PER_MS = 16000,
  parameter int RAMP_TICKS = 16000,
  parameter int STEP       = 160,
  parameter int MAX_DUTY   = 16000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_duty,
  input  logic        cmd_dir,
  input  logic [15:0] cmd_ms,
  input  logic        abort,
  output logic [15:0] timeon,
  output logic        pwm_en,
  output logic        dir,
  output logic        busy,
  output logic        done
);

  localparam int TW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_TICKS - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_PER_MS - 1);
  localparam logic [15:0]   STEP16    = 16'(STEP);
  localparam logic [15:0]   MAX16     = 16'(MAX_DUTY);

  typedef enum logic [2:0] {S_IDLE, S_UP, S_HOLD, S_DOWN, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [15:0]   r_target, r_dur, r_ms, r_timeon;
  logic [TW-1:0] r_tick;
  logic [PW-1:0] r_pre;
  logic          r_dir, r_pwm_en, r_busy, r_done, r_ready;
  logic          w_pwm_en_nxt, w_busy_nxt, w_done_nxt, w_ready_nxt;

  logic          w_capture, w_step, w_ms_tick, w_at_target, w_ms_hit;
  logic [16:0]   w_sum;
  logic [15:0]   w_up_val, w_dn_val;

  assign w_capture   = (r_state == S_IDLE) && cmd_valid;
  assign w_step      = (r_tick == TICK_LAST);
  assign w_ms_tick   = (r_pre == PRE_LAST);
  assign w_at_target = (r_timeon >= r_target);
  assign w_sum       = {1'b0, r_timeon} + {1'b0, STEP16};
  assign w_up_val    = (w_sum > {1'b0, r_target}) ? r_target : w_sum[15:0];
  assign w_dn_val    = (r_timeon > STEP16) ? (r_timeon - STEP16) : 16'd0;
  // Leave on the last prescaler cycle of the final ms so HOLD lasts exactly dur*CLK_PER_MS cycles.
  assign w_ms_hit    = (r_ms == r_dur) ||
                       (w_ms_tick && (({1'b0, r_ms} + 17'd1) == {1'b0, r_dur}));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_capture) w_next = S_UP;
      S_UP: begin
        if (abort)            w_next = S_DOWN;
        else if (w_at_target) w_next = S_HOLD;
      end
      S_HOLD: if (abort || w_ms_hit) w_next = S_DOWN;
      S_DOWN: if (r_timeon == 16'd0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pwm_en_nxt = (w_next == S_UP) || (w_next == S_HOLD) || (w_next == S_DOWN);
    w_busy_nxt   = (w_next != S_IDLE);
    w_done_nxt   = (w_next == S_DONE);
    w_ready_nxt  = (w_next == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_target <= '0;
      r_dur    <= '0;
      r_ms     <= '0;
      r_pre    <= '0;
      r_tick   <= '0;
      r_timeon <= '0;
      r_dir    <= 1'b0;
      r_pwm_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_pwm_en <= w_pwm_en_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_ready  <= w_ready_nxt;

      if (w_capture) begin
        r_target <= (cmd_duty > MAX16) ? MAX16 : cmd_duty;
        r_dir    <= cmd_dir;
        r_dur    <= cmd_ms;
      end

      // Tick counter restarts on entry to either ramp state.
      if ((w_next == r_state) && ((r_state == S_UP) || (r_state == S_DOWN)))
        r_tick <= w_step ? '0 : r_tick + TW'(1);
      else
        r_tick <= '0;

      if ((w_next == S_HOLD) && (r_state == S_HOLD)) begin
        r_pre <= w_ms_tick ? '0 : r_pre + PW'(1);
        if (w_ms_tick) r_ms <= r_ms + 16'd1;
      end else begin
        r_pre <= '0;
        r_ms  <= '0;
      end

      case (r_state)
        S_UP:   if (!w_at_target && w_step)       r_timeon <= w_up_val;
        S_DOWN: if ((r_timeon != 16'd0) && w_step) r_timeon <= w_dn_val;
        S_IDLE, S_DONE: r_timeon <= '0;
        default: ;
      endcase
    end
  end

  assign timeon    = r_timeon;
  assign pwm_en    = r_pwm_en;
  assign dir       = r_dir;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cmd_ready = r_ready;

endmodule

// File: tb/tb_motion_ramp.sv
// Directed bench for motion_ramp with small timing parameters; per-cycle traces are
// recorded after each command capture and compared against hand-derived cycle numbers.
module tb_motion_ramp;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_dir, abort;
  logic [15:0] cmd_duty, cmd_ms, timeon;
  logic        pwm_en, dir, busy, done;

  int n_chk = 0;
  int n_fail = 0;
  int tv[100], pe[100], dn[100], bz[100], rd[100], dr[100];

  motion_ramp #(.CLK_PER_MS(10), .RAMP_TICKS(4), .STEP(100), .MAX_DUTY(1000)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_duty(cmd_duty), .cmd_dir(cmd_dir), .cmd_ms(cmd_ms), .abort(abort),
    .timeon(timeon), .pwm_en(pwm_en), .dir(dir), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic start(input int duty, input int d, input int ms);
    cmd_duty  = 16'(duty);
    cmd_dir   = d[0];
    cmd_ms    = 16'(ms);
    cmd_valid = 1'b1;
  endtask

  // k=1 is the first sample after the capture edge.
  task automatic rec(input int n, input int drop_k, input int abort_k, input bit chg);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      tv[k] = timeon; pe[k] = pwm_en; dn[k] = done;
      bz[k] = busy;   rd[k] = cmd_ready; dr[k] = dir;
      if (k == drop_k) cmd_valid = 1'b0;
      if (k == 1 && chg) begin cmd_duty = 16'd200; cmd_dir = 1'b1; cmd_ms = 16'd0; end
      abort = (k == abort_k);
    end
  endtask

  function automatic int count_hi(input int a[100], input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (a[k] != 0) c++;
    return c;
  endfunction

  function automatic int max_of(input int a[100], input int n);
    int m = 0;
    for (int k = 1; k <= n; k++) if (a[k] > m) m = a[k];
    return m;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_duty = '0; cmd_dir = 1'b0; cmd_ms = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_timeon", timeon, 0);
    chk("rst_pwm_en", pwm_en, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dir", dir, 0);
    reset = 1'b0;

    // Basic command: 300, dir 1, 2 ms
    start(300, 1, 2);
    rec(50, 1, 0, 0);
    chk("t2_ready_k1", rd[1], 0);
    chk("t2_busy_k1", bz[1], 1);
    chk("t2_tv4", tv[4], 0);
    chk("t2_tv5", tv[5], 100);
    chk("t2_tv9", tv[9], 200);
    chk("t2_tv13", tv[13], 300);
    chk("t2_tv37", tv[37], 300);
    chk("t2_tv38", tv[38], 200);
    chk("t2_tv42", tv[42], 100);
    chk("t2_tv46", tv[46], 0);
    chk("t2_pe46", pe[46], 1);
    chk("t2_done47", dn[47], 1);
    chk("t2_pe47", pe[47], 0);
    chk("t2_busy47", bz[47], 1);
    chk("t2_done_cnt", count_hi(dn, 1, 50), 1);
    chk("t2_ready48", rd[48], 1);
    chk("t2_busy48", bz[48], 0);
    chk("t2_dir_hi", count_hi(dr, 1, 47), 47);
    chk("t2_ready_low", count_hi(rd, 1, 47), 0);

    // Saturation at target and at zero
    start(250, 0, 0);
    rec(32, 1, 0, 0);
    chk("t3_tv12", tv[12], 200);
    chk("t3_tv13", tv[13], 250);
    chk("t3_tv18", tv[18], 250);
    chk("t3_tv19", tv[19], 150);
    chk("t3_tv23", tv[23], 50);
    chk("t3_tv27", tv[27], 0);
    chk("t3_done28", dn[28], 1);

    // Clamp to MAX_DUTY
    start(5000, 0, 0);
    rec(88, 1, 0, 0);
    chk("t4_max", max_of(tv, 88), 1000);
    chk("t4_tv40", tv[40], 900);
    chk("t4_tv41", tv[41], 1000);
    chk("t4_tv47", tv[47], 900);
    chk("t4_tv83", tv[83], 0);
    chk("t4_done84", dn[84], 1);

    // Zero duty, zero duration
    start(0, 0, 0);
    rec(6, 1, 0, 0);
    chk("t4b_max", max_of(tv, 6), 0);
    chk("t4b_pe3", pe[3], 1);
    chk("t4b_done4", dn[4], 1);
    chk("t4b_pe4", pe[4], 0);
    chk("t4b_ready5", rd[5], 1);

    // Abort during ramp-up at 200
    start(500, 0, 3);
    rec(22, 1, 9, 0);
    chk("t5_tv9", tv[9], 200);
    chk("t5_tv13", tv[13], 200);
    chk("t5_tv14", tv[14], 100);
    chk("t5_tv18", tv[18], 0);
    chk("t5_done19", dn[19], 1);
    chk("t5_max", max_of(tv, 22), 200);
    chk("t5_done_cnt", count_hi(dn, 1, 22), 1);

    // cmd_valid held high across two commands
    start(100, 0, 0);
    rec(36, 14, 0, 1);
    chk("t6_ready_low", count_hi(rd, 1, 12), 0);
    chk("t6_dir12", dr[12], 0);
    chk("t6_done12", dn[12], 1);
    chk("t6_ready13", rd[13], 1);
    chk("t6_busy13", bz[13], 0);
    chk("t6_ready14", rd[14], 0);
    chk("t6_dir14", dr[14], 1);
    chk("t6_tv22", tv[22], 200);
    chk("t6_done33", dn[33], 1);
    chk("t6_done_cnt", count_hi(dn, 1, 36), 2);

    // Async reset in the middle of HOLD
    start(300, 1, 5);
    rec(20, 1, 0, 0);
    chk("t1_tv20", tv[20], 300);
    chk("t1_pe20", pe[20], 1);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_timeon", timeon, 0);
    chk("t1_async_pwm_en", pwm_en, 0);
    chk("t1_async_ready", cmd_ready, 1);
    chk("t1_async_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t1_idle_ready", cmd_ready, 1);
    chk("t1_idle_timeon", timeon, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
